// File: rtl/gate_truth_sequencer.sv
// gate_truth_sequencer: walks every input vector of a small combinational gate,
// holds each vector for SETTLE_CYCLES, samples the gate output and checks it
// against the expected truth table in TRUTH.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   start        begin a sweep (honoured only in IDLE or DONE)
//   dut_out      output of the gate under test
//   stim         current input vector driven to the gate (MSB = first input)
//   busy         high while settling or sampling
//   done         high once the sweep has finished
//   pass         valid with done; high when no vector mismatched
//   sample_valid one-cycle pulse when a vector result is recorded
//   sample_idx   vector index of the last recorded result
//   err_count    number of mismatching vectors (saturating)
//   fail_vec     bit i set when vector i mismatched
module gate_truth_sequencer #(
  parameter int unsigned                  N_INPUTS      = 2,
  parameter int unsigned                  SETTLE_CYCLES = 4,
  parameter logic [(2**N_INPUTS)-1:0]     TRUTH         = 4'b1011
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        dut_out,
  output logic [N_INPUTS-1:0]         stim,
  output logic                        busy,
  output logic                        done,
  output logic                        pass,
  output logic                        sample_valid,
  output logic [N_INPUTS-1:0]         sample_idx,
  output logic [7:0]                  err_count,
  output logic [(2**N_INPUTS)-1:0]    fail_vec
);

  localparam int unsigned V        = 2**N_INPUTS;
  localparam int unsigned CNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [N_INPUTS-1:0] LAST_VEC = N_INPUTS'(V - 1);
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [N_INPUTS-1:0]    stim_d;
  logic [N_INPUTS-1:0]    sample_idx_d;
  logic [7:0]             err_count_d;
  logic [V-1:0]           fail_vec_d;
  logic                   sample_valid_d;
  logic                   busy_d;
  logic                   done_d;
  logic                   pass_d;
  logic                   mismatch_c;

  // Case inequality so an X/Z gate output is treated as a mismatch.
  assign mismatch_c = (dut_out !== TRUTH[stim]);

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      stim         <= '0;
      sample_idx   <= '0;
      err_count    <= '0;
      fail_vec     <= '0;
      sample_valid <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      stim         <= stim_d;
      sample_idx   <= sample_idx_d;
      err_count    <= err_count_d;
      fail_vec     <= fail_vec_d;
      sample_valid <= sample_valid_d;
      busy         <= busy_d;
      done         <= done_d;
      pass         <= pass_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    stim_d         = stim;
    sample_idx_d   = sample_idx;
    err_count_d    = err_count;
    fail_vec_d     = fail_vec;
    sample_valid_d = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d     = SETTLE;
          stim_d      = '0;
          cnt_d       = '0;
          err_count_d = '0;
          fail_vec_d  = '0;
        end
      end
      SETTLE: begin
        if (cnt_q == CNT_LAST) begin
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SAMPLE: begin
        sample_valid_d = 1'b1;
        sample_idx_d   = stim;
        if (mismatch_c) begin
          fail_vec_d[stim] = 1'b1;
          if (err_count != 8'hFF) begin
            err_count_d = err_count + 8'd1;
          end
        end
        if (stim == LAST_VEC) begin
          state_d = DONE;
        end else begin
          stim_d  = stim + N_INPUTS'(1);
          cnt_d   = '0;
          state_d = SETTLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Status flags follow the state being entered so they stay registered.
    busy_d = (state_d == SETTLE) || (state_d == SAMPLE);
    done_d = (state_d == DONE);
    pass_d = (state_d == DONE) && (err_count_d == 8'd0);
  end

endmodule

// File: tb/tb_gate_truth_sequencer.sv
// Bench for gate_truth_sequencer: two instances (settle 4 and settle 1) each
// checking a bench-modelled gate with programmable truth table, output lag and
// an optional X vector. Expected sweep results come from a vector-level model.
module tb_gate_truth_sequencer;

  localparam logic [3:0] TRUTH = 4'b1011;

  logic       clk;
  logic       rst;
  logic       start    [2];
  logic       dut_out  [2];
  logic [1:0] stim_w   [2];
  logic       busy_w   [2];
  logic       done_w   [2];
  logic       pass_w   [2];
  logic       sv_w     [2];
  logic [1:0] sidx_w   [2];
  logic [7:0] err_w    [2];
  logic [3:0] fv_w     [2];

  // Gate model controls per instance.
  logic [3:0] gtab     [2];
  int         lag      [2];
  int         xvec     [2];
  logic [1:0] last_stim[2];
  logic [1:0] dly      [2][6];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  gate_truth_sequencer #(.N_INPUTS(2), .SETTLE_CYCLES(4), .TRUTH(TRUTH)) u_dut0 (
    .clk(clk), .rst(rst), .start(start[0]), .dut_out(dut_out[0]),
    .stim(stim_w[0]), .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
    .sample_valid(sv_w[0]), .sample_idx(sidx_w[0]), .err_count(err_w[0]),
    .fail_vec(fv_w[0])
  );

  gate_truth_sequencer #(.N_INPUTS(2), .SETTLE_CYCLES(1), .TRUTH(TRUTH)) u_dut1 (
    .clk(clk), .rst(rst), .start(start[1]), .dut_out(dut_out[1]),
    .stim(stim_w[1]), .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
    .sample_valid(sv_w[1]), .sample_idx(sidx_w[1]), .err_count(err_w[1]),
    .fail_vec(fv_w[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Delay line used to give the modelled gate an output lag in whole cycles.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      dly[d][0] <= stim_w[d];
      for (int j = 1; j < 6; j++) dly[d][j] <= dly[d][j-1];
    end
  end

  function automatic logic gate_fn(input logic [3:0] tab, input int xv, input logic [1:0] v);
    if (xv >= 0 && int'(v) == xv) return 1'bx;
    return tab[v];
  endfunction

  function automatic int settle(input int d);
    return (d == 0) ? 4 : 1;
  endfunction

  always @* begin
    for (int d = 0; d < 2; d++) begin
      logic [1:0] src;
      if (lag[d] == 0) src = stim_w[d];
      else             src = dly[d][lag[d]-1];
      dut_out[d] = gate_fn(gtab[d], xvec[d], src);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Vector-level reference: the gate sees vector i at the sample point when its
  // lag fits inside the hold window, otherwise it still shows the previous one.
  task automatic expect_sweep(input int d, input logic [1:0] pre,
                              output logic [7:0] e_err, output logic [3:0] e_fv);
    logic [3:0] tv;
    tv    = TRUTH;
    e_err = 8'd0;
    e_fv  = 4'd0;
    for (int i = 0; i < 4; i++) begin
      logic [1:0] src;
      logic       obs;
      if (lag[d] <= settle(d)) src = 2'(i);
      else if (i == 0)         src = pre;
      else                     src = 2'(i - 1);
      obs = gate_fn(gtab[d], xvec[d], src);
      if (obs !== tv[i]) begin
        e_fv[i] = 1'b1;
        e_err   = e_err + 8'd1;
      end
    end
  endtask

  task automatic check_idle_zero(input string tag, input int d);
    chk({tag, ".stim"}, 32'(stim_w[d]), 0);
    chk({tag, ".busy"}, 32'(busy_w[d]), 0);
    chk({tag, ".done"}, 32'(done_w[d]), 0);
    chk({tag, ".pass"}, 32'(pass_w[d]), 0);
    chk({tag, ".sv"},   32'(sv_w[d]),   0);
    chk({tag, ".sidx"}, 32'(sidx_w[d]), 0);
    chk({tag, ".err"},  32'(err_w[d]),  0);
    chk({tag, ".fv"},   32'(fv_w[d]),   0);
  endtask

  task automatic launch(input int d, output int k);
    @(negedge clk);
    start[d] = 1'b1;
    k = cyc + 1;
  endtask

  // Follows one sweep accepted at edge k until done, checking every sample.
  task automatic watch(input int d, input int k, input logic [1:0] pre,
                       input bit hold, input string tag);
    int         s;
    int         n;
    bit         fin;
    logic [7:0] e_err;
    logic [3:0] e_fv;
    s   = settle(d);
    n   = 0;
    fin = 1'b0;
    expect_sweep(d, pre, e_err, e_fv);
    for (int t = 0; t < 200 && !fin; t++) begin
      @(negedge clk);
      if (t == 0) begin
        if (!hold) start[d] = 1'b0;
        chk({tag, ".busy"}, 32'(busy_w[d]), 1);
      end
      if (sv_w[d]) begin
        chk({tag, ".idx"},   32'(sidx_w[d]), 32'(n));
        chk({tag, ".stime"}, 32'(cyc), 32'(k + (n + 1) * (s + 1)));
        n++;
      end
      if (done_w[d]) fin = 1'b1;
    end
    if (!fin) begin
      chk({tag, ".timeout"}, 0, 1);
    end else begin
      chk({tag, ".dtime"},   32'(cyc), 32'(k + 4 * (s + 1)));
      chk({tag, ".nsamp"},   32'(n), 4);
      chk({tag, ".err"},     32'(err_w[d]), 32'(e_err));
      chk({tag, ".fv"},      32'(fv_w[d]),  32'(e_fv));
      chk({tag, ".pass"},    32'(pass_w[d]), 32'(e_err == 8'd0));
      chk({tag, ".stim"},    32'(stim_w[d]), 3);
      chk({tag, ".busyend"}, 32'(busy_w[d]), 0);
      last_stim[d] = 2'd3;
    end
  endtask

  task automatic run(input int d, input bit hold, input string tag);
    int k;
    logic [1:0] pre;
    pre = last_stim[d];
    launch(d, k);
    watch(d, k, pre, hold, tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      start[d] = 1'b0; gtab[d] = TRUTH; lag[d] = 0; xvec[d] = -1; last_stim[d] = 2'd0;
    end
    #1 rst = 1'b1;
    #2;
    check_idle_zero("reset0", 0);
    check_idle_zero("reset1", 1);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Correct implication gate.
    run(0, 1'b0, "correct");

    // AND gate in place of implication: vectors 0 and 1 fail.
    gtab[0] = 4'b1000;
    run(0, 1'b0, "andgate");
    chk("andgate.fv_exact", 32'(fv_w[0]), 32'h3);

    // X on vector 3 only.
    gtab[0] = TRUTH; xvec[0] = 3;
    run(0, 1'b0, "xvec");
    xvec[0] = -1;

    // Short settle: one-cycle lag still passes, two-cycle lag does not.
    lag[1] = 1;
    run(1, 1'b0, "lag1");
    chk("lag1.pass_exact", 32'(pass_w[1]), 1);
    lag[1] = 2;
    run(1, 1'b0, "lag2");
    lag[1] = 0;

    // Reset during SETTLE of vector 2 with a broken gate so results are nonzero.
    gtab[0] = 4'b1000;
    launch(0, k);
    @(negedge clk);
    start[0] = 1'b0;
    while (cyc < k + 11) @(negedge clk);
    chk("rst.pre_stim", 32'(stim_w[0]), 2);
    chk("rst.pre_err",  32'(err_w[0]), 2);
    rst = 1'b1;
    #1;
    check_idle_zero("rst.mid", 0);
    @(negedge clk);
    rst = 1'b0;
    last_stim[0] = 2'd0; last_stim[1] = 2'd0;
    gtab[0] = TRUTH;
    run(0, 1'b0, "after_rst");
    chk("after_rst.pass_exact", 32'(pass_w[0]), 1);

    // Start held high: one sweep, then restart on the edge after done.
    gtab[0] = 4'b1000;
    run(0, 1'b1, "hold");
    @(negedge clk);
    k = cyc;
    chk("restart.done", 32'(done_w[0]), 0);
    chk("restart.stim", 32'(stim_w[0]), 0);
    chk("restart.err",  32'(err_w[0]), 0);
    chk("restart.fv",   32'(fv_w[0]), 0);
    chk("restart.busy", 32'(busy_w[0]), 1);
    start[0] = 1'b0;
    gtab[0] = TRUTH;
    watch(0, k, 2'd3, 1'b0, "restart");

    // Randomized gates, lags and X vectors on both instances.
    for (int it = 0; it < 12; it++) begin
      int d;
      d = int'($urandom_range(0, 1));
      gtab[d] = ($urandom_range(0, 1) == 0) ? TRUTH : 4'($urandom);
      lag[d]  = int'($urandom_range(0, settle(d) + 1));
      xvec[d] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run(d, 1'b0, $sformatf("rnd%0d", it));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
